// File: rtl/little_box_regfile.sv
// DEPTH x WIDTH register file: one save port, two registered load ports,
// per-entry valid bits, same-cycle write bypass, bulk clear, occupancy count.
module little_box_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             save,
  input  logic [AW-1:0]    save_addr,
  input  logic [WIDTH-1:0] value,
  input  logic             load_a,
  input  logic [AW-1:0]    addr_a,
  input  logic             load_b,
  input  logic [AW-1:0]    addr_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             valid_a,
  output logic             valid_b,
  output logic [AW:0]      used
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic             valid_a_q, valid_a_d;
  logic             valid_b_q, valid_b_d;
  logic [AW:0]      used_q, used_d;

  logic wr;
  logic hit_new;

  assign wr      = save & ~clear;
  assign hit_new = wr & ~vld_q[save_addr];

  // Bypass forwards the incoming word; clear forces every read to zero.
  always_comb begin
    out_a_d   = '0;
    valid_a_d = 1'b0;
    if (!clear && load_a) begin
      if (wr && addr_a == save_addr) begin
        out_a_d   = value;
        valid_a_d = 1'b1;
      end else begin
        out_a_d   = mem_q[addr_a];
        valid_a_d = vld_q[addr_a];
      end
    end
  end

  always_comb begin
    out_b_d   = '0;
    valid_b_d = 1'b0;
    if (!clear && load_b) begin
      if (wr && addr_b == save_addr) begin
        out_b_d   = value;
        valid_b_d = 1'b1;
      end else begin
        out_b_d   = mem_q[addr_b];
        valid_b_d = vld_q[addr_b];
      end
    end
  end

  always_comb begin
    used_d = used_q;
    if (clear)
      used_d = '0;
    else if (hit_new && used_q != FULL)
      used_d = used_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      vld_q     <= '0;
      out_a_q   <= '0;
      out_b_q   <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      used_q    <= '0;
    end else begin
      if (clear) begin
        for (int i = 0; i < DEPTH; i++)
          mem_q[i] <= '0;
        vld_q <= '0;
      end else if (save) begin
        mem_q[save_addr] <= value;
        vld_q[save_addr] <= 1'b1;
      end
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
      used_q    <= used_d;
    end
  end

  assign out_a   = out_a_q;
  assign out_b   = out_b_q;
  assign valid_a = valid_a_q;
  assign valid_b = valid_b_q;
  assign used    = used_q;

endmodule

// File: tb/tb_little_box_regfile.sv
// Directed bench for little_box_regfile: expected results queued at drive
// time, popped and checked one cycle later.
module tb_little_box_regfile;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       save;
  logic [1:0] save_addr;
  logic [7:0] value;
  logic       load_a;
  logic [1:0] addr_a;
  logic       load_b;
  logic [1:0] addr_b;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic       valid_a;
  logic       valid_b;
  logic [2:0] used;

  int checks;
  int failures;

  typedef struct {
    logic [7:0] oa;
    logic       va;
    logic [7:0] ob;
    logic       vb;
    logic [2:0] u;
  } exp_t;

  exp_t sb[$];

  little_box_regfile #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .save(save),
    .save_addr(save_addr),
    .value(value),
    .load_a(load_a),
    .addr_a(addr_a),
    .load_b(load_b),
    .addr_b(addr_b),
    .out_a(out_a),
    .out_b(out_b),
    .valid_a(valid_a),
    .valid_b(valid_b),
    .used(used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".out_a"},   32'(out_a),   32'(e.oa));
    chk({tag, ".valid_a"}, 32'(valid_a), 32'(e.va));
    chk({tag, ".out_b"},   32'(out_b),   32'(e.ob));
    chk({tag, ".valid_b"}, 32'(valid_b), 32'(e.vb));
    chk({tag, ".used"},    32'(used),    32'(e.u));
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge.
  task automatic step(input string tag,
                      input logic clr, input logic sv,
                      input logic [1:0] sa, input logic [7:0] val,
                      input logic la, input logic [1:0] aa,
                      input logic lb, input logic [1:0] ab,
                      input logic [7:0] eoa, input logic eva,
                      input logic [7:0] eob, input logic evb,
                      input logic [2:0] eu);
    exp_t e;
    clear = clr; save = sv; save_addr = sa; value = val;
    load_a = la; addr_a = aa; load_b = lb; addr_b = ab;
    e.oa = eoa; e.va = eva; e.ob = eob; e.vb = evb; e.u = eu;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      chk_all(tag, sb.pop_front());
    end
  endtask

  task automatic idle();
    clear = 0; save = 0; save_addr = 0; value = 0;
    load_a = 0; addr_a = 0; load_b = 0; addr_b = 0;
  endtask

  initial begin
    exp_t z;
    checks = 0;
    failures = 0;
    z.oa = 0; z.va = 0; z.ob = 0; z.vb = 0; z.u = 0;
    rst = 1'b0;
    idle();
    #1;
    chk_all("reset_hold", z);
    @(posedge clk);
    #1;
    chk_all("reset_edge", z);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    step("rd_unwritten", 0, 0, 0, 8'h00, 1, 2, 0, 0,
         8'h00, 0, 8'h00, 0, 3'd0);
    step("wr1",          0, 1, 1, 8'hA5, 0, 0, 0, 0,
         8'h00, 0, 8'h00, 0, 3'd1);
    step("rd1",          0, 0, 0, 8'h00, 1, 1, 0, 0,
         8'hA5, 1, 8'h00, 0, 3'd1);
    step("bypass3",      0, 1, 3, 8'h3C, 1, 3, 1, 3,
         8'h3C, 1, 8'h3C, 1, 3'd2);
    step("fill0",        0, 1, 0, 8'h11, 0, 0, 0, 0,
         8'h00, 0, 8'h00, 0, 3'd3);
    step("fill1",        0, 1, 1, 8'h22, 1, 3, 0, 0,
         8'h3C, 1, 8'h00, 0, 3'd3);
    step("fill2",        0, 1, 2, 8'h33, 0, 0, 1, 1,
         8'h00, 0, 8'h22, 1, 3'd4);
    step("fill3",        0, 1, 3, 8'h44, 1, 0, 0, 0,
         8'h11, 1, 8'h00, 0, 3'd4);
    step("over0",        0, 1, 0, 8'hFF, 0, 0, 1, 3,
         8'h00, 0, 8'h44, 1, 3'd4);
    step("rd_over",      0, 0, 0, 8'h00, 1, 0, 1, 2,
         8'hFF, 1, 8'h33, 1, 3'd4);
    step("same_addr",    0, 0, 0, 8'h00, 1, 1, 1, 1,
         8'h22, 1, 8'h22, 1, 3'd4);
    step("clear_save",   1, 1, 2, 8'h77, 1, 1, 1, 2,
         8'h00, 0, 8'h00, 0, 3'd0);
    step("rd_cleared",   0, 0, 0, 8'h00, 1, 2, 1, 1,
         8'h00, 0, 8'h00, 0, 3'd0);
    step("wr0_post",     0, 1, 0, 8'h5A, 0, 0, 0, 0,
         8'h00, 0, 8'h00, 0, 3'd1);
    step("wr1_post",     0, 1, 1, 8'h6B, 0, 0, 0, 0,
         8'h00, 0, 8'h00, 0, 3'd2);
    step("rd_pre_rst",   0, 1, 2, 8'h99, 1, 0, 1, 1,
         8'h5A, 1, 8'h6B, 1, 3'd3);

    // Mid-cycle async reset while a write is being presented.
    save = 1; save_addr = 3; value = 8'hEE;
    #2 rst = 1'b0;
    #1;
    chk_all("async_rst", z);
    @(posedge clk);
    #1;
    chk_all("rst_held", z);
    #2 rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step("rd_after_rst", 0, 0, 0, 8'h00, 1, 0, 1, 1,
         8'h00, 0, 8'h00, 0, 3'd0);
    step("rd_after_rst2", 0, 0, 0, 8'h00, 1, 3, 1, 2,
         8'h00, 0, 8'h00, 0, 3'd0);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
